// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone target RAM with byte-lane writes, wait states and a post-ack guard window
module wb_mem_responder #(
  parameter int    MEM_WORDS   = 1024,
  parameter int    WAIT_STATES = 0,
  parameter int    ACK_GAP     = 1,
  parameter string MEMORY_FILE = ""
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_mem [MEM_WORDS];
  logic [AW-1:0] w_word;
  logic          w_in_range;
  logic          w_commit;
  assign w_word     = r_addr[2 +: AW];
  assign w_in_range = (r_addr >> (AW + 2)) == 32'd0;
  assign w_commit   = r_state == WAIT && r_cnt == 4'd0;
  always_ff @(posedge clk_core)
    if (!rst_core && w_commit && r_we && w_in_range)
      for (int i = 0; i < 4; i++)
        if (r_sel[i]) r_mem[w_word][8*i +: 8] <= r_data[8*i +: 8];
  always_ff @(posedge clk_core)
    if (rst_core) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      ack_o   <= 1'b0;
      data_o  <= 32'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
    end else begin
      ack_o <= 1'b0;
      case (r_state)
        IDLE:
          if (cyc_i && stb_i) begin
            r_state <= WAIT;
            r_cnt   <= 4'(WAIT_STATES);
            r_addr  <= addr_i;
            r_data  <= data_i;
            r_we    <= we_i;
            r_sel   <= sel_i;
          end
        WAIT:
          if (r_cnt == 4'd0) begin
            r_state <= ACK;
            ack_o   <= 1'b1;
            if (!r_we) data_o <= w_in_range ? r_mem[w_word] : 32'd0;
          end else r_cnt <= r_cnt - 4'd1;
        ACK: begin
          r_state <= GAP;
          r_cnt   <= 4'(ACK_GAP - 1);
        end
        GAP:
          if (r_cnt == 4'd0) r_state <= IDLE;
          else r_cnt <= r_cnt - 4'd1;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_mem_responder.sv
// tb_wb_mem_responder: two responder instances (no wait / 3 wait states) checked every cycle against a
// transaction-timing model, plus directed literal checks.
module tb_wb_mem_responder;
   localparam int WS[2] = '{0, 3};
   localparam int GS[2] = '{1, 2};
   localparam int DP[2] = '{1024, 16};
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst[2], cyc[2], stb[2], we[2], ack[2];
   logic [3:0]  sel[2];
   logic [31:0] addr[2], wdat[2], rdat[2];
   wb_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .ACK_GAP(1), .MEMORY_FILE("")) u0 (
      .clk_core(clk), .rst_core(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .sel_i(sel[0]),
      .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]), .ack_o(ack[0]));
   wb_mem_responder #(.MEM_WORDS(16), .WAIT_STATES(3), .ACK_GAP(2), .MEMORY_FILE("")) u1 (
      .clk_core(clk), .rst_core(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .sel_i(sel[1]),
      .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]), .ack_o(ack[1]));
   // model: a capture at edge e acks at edge e+1+W and frees the target at edge e+3+W+G
   int          ecnt = 0;
   int          ack_at[2], free_at[2];
   bit          pend[2], started[2], eack[2], eknown[2];
   logic [31:0] edat[2], ta[2], td[2];
   bit          twe[2];
   logic [3:0]  tsel[2];
   logic [31:0] mem[2][1024];
   bit   [3:0]  kn[2][1024];
   logic        inr;
   int          idx;
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            pend[k] = 0; eack[k] = 0; edat[k] = 32'h0; eknown[k] = 1;
            free_at[k] = ecnt + 1; started[k] = 1;
         end else begin
            eack[k] = 0;
            if (pend[k] && ecnt == ack_at[k]) begin
               pend[k] = 0; eack[k] = 1;
               inr = longint'(ta[k] >> 2) < longint'(DP[k]);
               idx = inr ? int'(ta[k] >> 2) : 0;
               if (twe[k]) begin
                  if (inr)
                     for (int b = 0; b < 4; b++)
                        if (tsel[k][b]) begin
                           mem[k][idx][8*b +: 8] = td[k][8*b +: 8];
                           kn[k][idx][b] = 1'b1;
                        end
               end else begin
                  edat[k] = inr ? mem[k][idx] : 32'h0;
                  eknown[k] = !inr || (&kn[k][idx]);
               end
            end
            if (started[k] && ecnt >= free_at[k] && cyc[k] && stb[k]) begin
               pend[k] = 1; ta[k] = addr[k]; td[k] = wdat[k]; twe[k] = we[k]; tsel[k] = sel[k];
               ack_at[k] = ecnt + 1 + WS[k];
               free_at[k] = ecnt + 3 + WS[k] + GS[k];
            end
         end
      end
      ecnt++;
   end
   int ntest = 0, nfail = 0;
   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s[u%0d] t=%0t: got %h, want %h", nm, k, $time, act, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if (started[k]) begin
            chk("ack_o", k, {31'd0, ack[k]}, {31'd0, eack[k]});
            if (eknown[k]) chk("data_o", k, rdat[k], edat[k]);
         end
   endtask
   task automatic idle(int k);
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 4'h0; addr[k] = 32'h0; wdat[k] = 32'h0;
   endtask
   task automatic xfer(int k, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d, output int cnt);
      cyc[k] = 1; stb[k] = 1; we[k] = w; sel[k] = s; addr[k] = a; wdat[k] = d;
      cnt = 0;
      do begin step(); cnt++; end while (!ack[k] && cnt < 40);
      chk("xfer_ack_seen", k, {31'd0, ack[k]}, 32'd1);
      idle(k);
      repeat (GS[k] + 1) step();
   endtask
   function automatic logic [31:0] pick(int k);
      int r = int'($urandom_range(0, 9));
      if (r < 8) return 32'(r * 4) + $urandom_range(0, 3);
      if (r == 8) return 32'(4 * DP[k]) + 32'(4 * $urandom_range(0, 7));
      return $urandom | 32'h8000_0000;
   endfunction
   initial begin
      int lat, ackc;
      for (int k = 0; k < 2; k++) begin rst[k] = 1; idle(k); end
      step(); step();
      chk("reset_ack", 0, {31'd0, ack[0]}, 32'd0);
      chk("reset_data", 1, rdat[1], 32'h0);
      rst[0] = 0; rst[1] = 0;
      step();
      // full write then read, no wait states
      xfer(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, lat); chk("t1_wr_lat", 0, lat, 2);
      xfer(0, 0, 4'hF, 32'h10, 32'h0, lat);        chk("t1_rd_lat", 0, lat, 2);
      chk("t1_rd", 0, rdat[0], 32'hDEADBEEF);
      // byte lanes and empty select
      xfer(0, 1, 4'b0010, 32'h10, 32'h0000AB00, lat);
      xfer(0, 0, 4'hF, 32'h10, 32'h0, lat);        chk("t2_lane", 0, rdat[0], 32'hDEADABEF);
      xfer(0, 1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat);
      xfer(0, 0, 4'h0, 32'h12, 32'h0, lat);        chk("t2_sel0", 0, rdat[0], 32'hDEADABEF);
      // out of range, no aliasing
      xfer(0, 1, 4'hF, 32'h0, 32'hA5A50001, lat);
      xfer(0, 0, 4'hF, 32'h1000, 32'h0, lat);      chk("t5_oor_rd", 0, rdat[0], 32'h0);
      xfer(0, 1, 4'hF, 32'h1000, 32'h12345678, lat);
      xfer(0, 0, 4'hF, 32'h0, 32'h0, lat);         chk("t5_word0", 0, rdat[0], 32'hA5A50001);
      xfer(0, 1, 4'hF, 32'h1010, 32'h0BADBEEF, lat);
      xfer(0, 0, 4'hF, 32'h10, 32'h0, lat);        chk("t5_noalias", 0, rdat[0], 32'hDEADABEF);
      // strobe held past ack: exactly two services
      cyc[0] = 1; stb[0] = 1; we[0] = 1; sel[0] = 4'hF; addr[0] = 32'h20; wdat[0] = 32'h0BADF00D;
      ackc = 0;
      repeat (5) begin step(); ackc += int'(ack[0]); end
      idle(0);
      repeat (10) begin step(); ackc += int'(ack[0]); end
      chk("t4_acks", 0, ackc, 2);
      xfer(0, 0, 4'hF, 32'h20, 32'h0, lat);        chk("t4_rd", 0, rdat[0], 32'h0BADF00D);
      // three wait states
      xfer(1, 1, 4'hF, 32'hC, 32'h11223344, lat);  chk("t3_wr_lat", 1, lat, 5);
      xfer(1, 0, 4'hF, 32'hC, 32'h0, lat);         chk("t3_rd_lat", 1, lat, 5);
      chk("t3_rd", 1, rdat[1], 32'h11223344);
      ackc = 0;
      repeat (6) begin step(); ackc += int'(ack[1]); end
      chk("t3_single_ack", 1, ackc, 0);
      // reset during WAIT drops the write
      xfer(1, 1, 4'hF, 32'h8, 32'hCAFE0002, lat);
      xfer(1, 0, 4'hF, 32'hC, 32'h0, lat);
      cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; addr[1] = 32'h8; wdat[1] = 32'hFFFFFFFF;
      step();
      rst[1] = 1; idle(1);
      step();
      chk("t6_rst_data", 1, rdat[1], 32'h0);
      rst[1] = 0;
      ackc = 0;
      repeat (8) begin step(); ackc += int'(ack[1]); end
      chk("t6_no_ack", 1, ackc, 0);
      xfer(1, 0, 4'hF, 32'h8, 32'h0, lat);         chk("t6_lat", 1, lat, 5);
      chk("t6_word", 1, rdat[1], 32'hCAFE0002);
      // randomized traffic
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 8; w++) xfer(k, 1, 4'hF, 32'(4 * w), $urandom, lat);
         for (int c = 0; c < 2500; c++) begin
            step();
            rst[k] = $urandom_range(0, 199) == 0;
            cyc[k] = $urandom_range(0, 3) != 0;
            stb[k] = 1'($urandom_range(0, 1));
            we[k] = 1'($urandom_range(0, 1));
            sel[k] = 4'($urandom);
            addr[k] = pick(k);
            wdat[k] = $urandom;
         end
         rst[k] = 0; idle(k);
         repeat (12) step();
      end
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
